mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of wait-state cycles inserted per access (legal 0..15).
REQ-002 Parameter DEPTH_BYTES, default 512, byte capacity of the internal storage array (power of two, 2..65536).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset: synchronous and active-high.
REQ-005 MemRead  input  1  read request strobe from the control FSM.
REQ-006 MemWrite  input  1  write request strobe from the control FSM.
REQ-007 BorD  input  1  access size: 1 = 16-bit word, 0 = byte.
REQ-008 SignExt  input  1  byte reads only: 1 = sign-extend bit 7, 0 = zero-extend.
REQ-009 Addr  input  16  byte address.
REQ-010 WData  input  16  write data; byte writes use WData[7:0].
REQ-011 RData  output  16  read data, registered.
REQ-012 Ready  output  1  one-cycle completion pulse.
REQ-013 Busy  output  1  access in progress; new requests are ignored.
REQ-014 Err  output  1  misaligned-access flag (see Configuration).

Function
REQ-015 FSM states: IDLE, WAIT, DONE; after reset the state is IDLE.
REQ-016 In IDLE, MemRead=1 or MemWrite=1 in cycle N accepts a request; Addr, WData, BorD, SignExt and the operation are latched in cycle N.
REQ-017 If both MemRead and MemWrite are 1 at acceptance, the request is a read; the write is dropped.
REQ-018 After acceptance the FSM spends exactly WAIT_CYCLES cycles in WAIT (skipped when 0), then enters DONE; Ready=1 in DONE only, i.e. in cycle N+WAIT_CYCLES+1.
REQ-019 Busy=1 from cycle N+1 through the Ready cycle inclusive; strobes in that window are ignored, not queued.
REQ-020 DONE always returns to IDLE next cycle; a request present in that IDLE cycle is accepted (back-to-back throughput WAIT_CYCLES+2 cycles).
REQ-021 Storage little-endian: word at even address A holds low byte at A, high byte at A+1.
REQ-022 Effective byte address = latched Addr modulo DEPTH_BYTES (wrap-around, no error).
REQ-023 Writes commit to storage on the DONE-cycle edge only; byte write modifies one byte, word write two.
REQ-024 Reads: RData updated on the DONE-cycle edge, valid together with Ready; byte read returns the selected byte extended per SignExt to 16 bits.
REQ-025 RData holds its value through writes and idle cycles until the next read completes.
REQ-026 Strobes falling before Ready do not cancel an accepted access.

Reset
REQ-027 With rst=1 at a rising edge: state=IDLE, Ready=0, Busy=0, Err=0, RData=16'h0000.
REQ-028 Reset mid-access aborts it; an uncommitted write is discarded and no Ready pulse follows.
REQ-029 Storage contents are not cleared by reset.
REQ-030 rst has priority over any simultaneous request.

Configuration
REQ-031 Macro MEM_RESP_ALIGN_CHECK_EN selects misalignment handling.
REQ-032 Defined: a word access with Addr[0]=1 completes with normal timing, Ready and Err both 1 in the DONE cycle; no storage change, RData unchanged; Err=0 otherwise.
REQ-033 Undefined: Addr[0] is ignored for word accesses (forced to even address) and Err is tied 0.

Verification
REQ-034 WAIT_CYCLES=1: word write 16'hBEEF to 0x0010 accepted cycle 0 -> Busy cycles 1-2, Ready cycle 2 only; word read 0x0010 -> RData=16'hBEEF with Ready.
REQ-035 Byte write 8'h80 to 0x0011, then byte read 0x0011 SignExt=1 -> 16'hFF80; SignExt=0 -> 16'h0080; word read 0x0010 -> 16'h80EF.
REQ-036 MemRead and MemWrite both 1, WData=16'h1234, Addr 0x0010 -> read returns 16'h80EF, storage unchanged.
REQ-037 Word write 16'hAAAA to DEPTH_BYTES+4 -> word read 0x0004 returns 16'hAAAA; WAIT_CYCLES=0 -> Ready one cycle after acceptance.
REQ-038 rst=1 asserted in WAIT of word write 16'h5555 to 0x0020 -> no Ready, Busy=0 next cycle, read 0x0020 returns prior contents.
REQ-039 Word read at 0x0021: with MEM_RESP_ALIGN_CHECK_EN -> Ready=1, Err=1, RData unchanged; without -> data of 0x0020, Err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-state byte/word memory with Ready/Busy handshake.
// Optional macro MEM_RESP_ALIGN_CHECK_EN flags misaligned word accesses.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned DEPTH_BYTES = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        BorD,
   input  logic        SignExt,
   input  logic [15:0] Addr,
   input  logic [15:0] WData,
   output logic [15:0] RData,
   output logic        Ready,
   output logic        Busy,
   output logic        Err
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);
   localparam logic [AW-1:0] ONE = AW'(1);
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        word_q, word_d;
   logic        sext_q, sext_d;
   logic        rd_q, rd_d;
   logic [15:0] rdata_q, rdata_d;

   logic [7:0]  mem_q [DEPTH_BYTES];

   logic [AW-1:0] ea_lo;
   logic [AW-1:0] ea_hi;
   logic [7:0]    byte_v;
   logic [15:0]   word_v;
   logic          bad;
   logic          we_lo;
   logic          we_hi;

   // Next-state logic: request capture, wait-state countdown, completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      sext_d  = sext_q;
      rd_d    = rd_q;
      unique case (state_q)
         IDLE: begin
            if (MemRead || MemWrite) begin
               addr_d  = Addr;
               wdata_d = WData;
               word_d  = BorD;
               sext_d  = SignExt;
               rd_d    = MemRead;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: the access takes effect on the edge that enters DONE,
   // so read data is valid in the same cycle as Ready.
   always_comb begin
      ea_lo = addr_d[AW-1:0];
      if (word_d) begin
         ea_lo = ea_lo & ~ONE;
      end
      ea_hi  = ea_lo | ONE;
      byte_v = mem_q[ea_lo];
      word_v = {mem_q[ea_hi], mem_q[ea_lo]};
`ifdef MEM_RESP_ALIGN_CHECK_EN
      bad = word_d & addr_d[0];
`else
      bad = 1'b0;
`endif
      we_lo   = (state_d == DONE) && !rd_d && !bad && !rst;
      we_hi   = we_lo && word_d;
      rdata_d = rdata_q;
      if ((state_d == DONE) && rd_d && !bad) begin
         if (word_d) begin
            rdata_d = word_v;
         end else begin
            rdata_d = {{8{sext_d & byte_v[7]}}, byte_v};
         end
      end
   end

   // Control and read-data registers; reset wins over any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         word_q  <= 1'b0;
         sext_q  <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         sext_q  <= sext_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage array: never cleared, little-endian byte lanes.
   always_ff @(posedge clk) begin
      if (we_lo) begin
         mem_q[ea_lo] <= wdata_d[7:0];
      end
      if (we_hi) begin
         mem_q[ea_hi] <= wdata_d[15:8];
      end
   end

   assign RData = rdata_q;
   assign Ready = (state_q == DONE);
   assign Busy  = (state_q != IDLE);
`ifdef MEM_RESP_ALIGN_CHECK_EN
   assign Err = (state_q == DONE) && word_q && addr_q[0];
`else
   assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder timing and data.
// Second instance runs with zero wait states.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite, BorD, SignExt;
   logic [15:0] Addr, WData, RData;
   logic        Ready, Busy, Err;

   logic        z_rst;
   logic        z_rd, z_wr, z_bord, z_sext;
   logic [15:0] z_addr, z_wdata, z_rdata;
   logic        z_ready, z_busy, z_err;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_responder #(.WAIT_CYCLES(1), .DEPTH_BYTES(512)) u_dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .BorD(BorD), .SignExt(SignExt), .Addr(Addr), .WData(WData),
      .RData(RData), .Ready(Ready), .Busy(Busy), .Err(Err)
   );

   mem_responder #(.WAIT_CYCLES(0), .DEPTH_BYTES(64)) u_dut0 (
      .clk(clk), .rst(z_rst), .MemRead(z_rd), .MemWrite(z_wr),
      .BorD(z_bord), .SignExt(z_sext), .Addr(z_addr), .WData(z_wdata),
      .RData(z_rdata), .Ready(z_ready), .Busy(z_busy), .Err(z_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, release strobes, wait (bounded) for Ready.
   // lat = cycles from acceptance to Ready; bsy = Busy cycles seen.
   task automatic access(input logic rd, input logic wr, input logic wd,
                         input logic sx, input logic [15:0] a,
                         input logic [15:0] d, output int lat,
                         output int bsy, output logic [15:0] rdat,
                         output logic er, output logic rdy_after);
      MemRead = rd; MemWrite = wr; BorD = wd; SignExt = sx;
      Addr = a; WData = d;
      tick();
      MemRead = 1'b0; MemWrite = 1'b0;
      lat = 1; bsy = 0;
      while (!Ready && lat < 20) begin
         if (Busy) bsy++;
         tick();
         lat++;
      end
      if (Busy) bsy++;
      rdat = RData; er = Err;
      tick();
      rdy_after = Ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_run++; if (Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", Ready); end
      n_run++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", Busy); end
      n_run++; if (Err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", Err); end
      n_run++; if (RData !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", RData); end
   endtask

   task automatic test_word();
      int lat, bsy; logic [15:0] r; logic e, ra;
      access(0, 1, 1, 0, 16'h0010, 16'hBEEF, lat, bsy, r, e, ra);
      n_run++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
      n_run++; if (bsy !== 2) begin n_fail++; $display("FAIL wr_busy_cycles: got %0d want 2", bsy); end
      n_run++; if (ra !== 1'b0) begin n_fail++; $display("FAIL wr_ready_pulse: got %b want 0", ra); end
      n_run++; if (RData !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 0000", RData); end
      access(1, 0, 1, 0, 16'h0010, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'hBEEF) begin n_fail++; $display("FAIL rd_word: got %h want beef", r); end
      n_run++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d want 2", lat); end
   endtask

   task automatic test_byte();
      int lat, bsy; logic [15:0] r; logic e, ra;
      access(0, 1, 0, 0, 16'h0011, 16'h3380, lat, bsy, r, e, ra);
      access(1, 0, 0, 1, 16'h0011, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'hFF80) begin n_fail++; $display("FAIL byte_sext: got %h want ff80", r); end
      access(1, 0, 0, 0, 16'h0011, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h0080) begin n_fail++; $display("FAIL byte_zext: got %h want 0080", r); end
      access(1, 0, 1, 0, 16'h0010, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h80EF) begin n_fail++; $display("FAIL byte_merge: got %h want 80ef", r); end
      access(1, 0, 0, 1, 16'h0010, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'hFFEF) begin n_fail++; $display("FAIL byte_lo_sext: got %h want ffef", r); end
   endtask

   task automatic test_both();
      int lat, bsy; logic [15:0] r; logic e, ra;
      access(1, 1, 1, 0, 16'h0010, 16'h1234, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h80EF) begin n_fail++; $display("FAIL both_read: got %h want 80ef", r); end
      access(1, 0, 1, 0, 16'h0010, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h80EF) begin n_fail++; $display("FAIL both_nowrite: got %h want 80ef", r); end
   endtask

   task automatic test_wrap_hold();
      int lat, bsy; logic [15:0] r; logic e, ra;
      access(0, 1, 1, 0, 16'h0204, 16'hAAAA, lat, bsy, r, e, ra);
      access(1, 0, 1, 0, 16'h0004, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'hAAAA) begin n_fail++; $display("FAIL wrap_read: got %h want aaaa", r); end
      access(0, 1, 1, 0, 16'h0030, 16'h1111, lat, bsy, r, e, ra);
      tick(); tick();
      n_run++; if (RData !== 16'hAAAA) begin n_fail++; $display("FAIL rdata_hold: got %h want aaaa", RData); end
   endtask

   task automatic test_ignore_busy();
      int lat, bsy; logic [15:0] r; logic e, ra;
      MemRead = 1'b1; MemWrite = 1'b0; BorD = 1'b1; Addr = 16'h0004;
      tick();
      MemRead = 1'b0; MemWrite = 1'b1; WData = 16'h9999; Addr = 16'h0030;
      tick();
      MemWrite = 1'b0;
      n_run++; if (Ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready: got %b want 1", Ready); end
      n_run++; if (RData !== 16'hAAAA) begin n_fail++; $display("FAIL ign_rdata: got %h want aaaa", RData); end
      tick(); tick(); tick();
      n_run++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued: got %b want 0", Busy); end
      access(1, 0, 1, 0, 16'h0030, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h1111) begin n_fail++; $display("FAIL ign_storage: got %h want 1111", r); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] pat;
      pat = '0;
      MemRead = 1'b1; MemWrite = 1'b0; BorD = 1'b1; Addr = 16'h0010;
      for (int k = 1; k <= 6; k++) begin
         tick();
         pat[k-1] = Ready;
         if (k == 5) MemRead = 1'b0;
      end
      tick(); tick();
      n_run++; if (pat !== 6'b010010) begin n_fail++; $display("FAIL b2b_ready: got %b want 010010", pat); end
      n_run++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", Busy); end
   endtask

   task automatic test_reset_mid();
      int lat, bsy; logic [15:0] r; logic e, ra; logic seen;
      access(0, 1, 1, 0, 16'h0020, 16'h1357, lat, bsy, r, e, ra);
      MemWrite = 1'b1; BorD = 1'b1; Addr = 16'h0020; WData = 16'h5555;
      tick();
      MemWrite = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_run++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", Busy); end
      n_run++; if (RData !== 16'h0000) begin n_fail++; $display("FAIL mid_rdata: got %h want 0000", RData); end
      seen = Ready;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen = seen | Ready;
      end
      n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_ready: got %b want 0", seen); end
      access(1, 0, 1, 0, 16'h0020, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== 16'h1357) begin n_fail++; $display("FAIL mid_storage: got %h want 1357", r); end
   endtask

   task automatic test_align();
      int lat, bsy; logic [15:0] r; logic e, ra;
      logic [15:0] exp_r, exp_w; logic exp_e;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      exp_r = 16'h80EF; exp_e = 1'b1; exp_w = 16'h1357;
`else
      exp_r = 16'h1357; exp_e = 1'b0; exp_w = 16'hDEAD;
`endif
      access(1, 0, 1, 0, 16'h0010, 16'h0000, lat, bsy, r, e, ra);
      access(1, 0, 1, 0, 16'h0021, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== exp_r) begin n_fail++; $display("FAIL align_rdata: got %h want %h", r, exp_r); end
      n_run++; if (e !== exp_e) begin n_fail++; $display("FAIL align_err: got %b want %b", e, exp_e); end
      n_run++; if (lat !== 2) begin n_fail++; $display("FAIL align_latency: got %0d want 2", lat); end
      access(0, 1, 1, 0, 16'h0021, 16'hDEAD, lat, bsy, r, e, ra);
      access(1, 0, 1, 0, 16'h0020, 16'h0000, lat, bsy, r, e, ra);
      n_run++; if (r !== exp_w) begin n_fail++; $display("FAIL align_write: got %h want %h", r, exp_w); end
      n_run++; if (e !== 1'b0) begin n_fail++; $display("FAIL align_err_clear: got %b want 0", e); end
   endtask

   task automatic test_wait0();
      int lat;
      z_rst = 1'b1;
      tick();
      z_rst = 1'b0;
      z_wr = 1'b1; z_bord = 1'b1; z_addr = 16'h0048; z_wdata = 16'h00C3;
      tick();
      z_wr = 1'b0;
      n_run++; if (z_ready !== 1'b1) begin n_fail++; $display("FAIL w0_wr_ready: got %b want 1", z_ready); end
      tick();
      z_rd = 1'b1; z_addr = 16'h0008;
      tick();
      z_rd = 1'b0;
      lat = 1;
      n_run++; if (z_ready !== 1'b1) begin n_fail++; $display("FAIL w0_rd_ready: got %b want 1 (lat %0d)", z_ready, lat); end
      n_run++; if (z_rdata !== 16'h00C3) begin n_fail++; $display("FAIL w0_rd_data: got %h want 00c3", z_rdata); end
      tick();
      n_run++; if (z_ready !== 1'b0) begin n_fail++; $display("FAIL w0_pulse: got %b want 0", z_ready); end
   endtask

   initial begin
      rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; BorD = 1'b0;
      SignExt = 1'b0; Addr = '0; WData = '0;
      z_rst = 1'b0; z_rd = 1'b0; z_wr = 1'b0; z_bord = 1'b0;
      z_sext = 1'b0; z_addr = '0; z_wdata = '0;
      #1;
      test_reset();
      test_word();
      test_byte();
      test_both();
      test_wrap_hold();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_align();
      test_wait0();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
